serial_ripple_subtractor: RTL

Multi-cycle, bit-serial ripple subtractor that computes Diff = A − B − Bin one bit per clock. It is the inverse-direction companion to the team's combinational 4-bit ripple adder and uses the same width and operand conventions, so the two can be cross-checked against each other in benches. It sits behind a start/done handshake, so upstream logic can issue a subtraction and collect a registered, stable result.

---
 rtl/serial_ripple_subtractor_if.sv | 14 +
 rtl/serial_ripple_subtractor.sv | 59 +++++
 2 files changed

// File: rtl/serial_ripple_subtractor_if.sv
// serial_ripple_subtractor_if: start/done request and result bundle for the bit-serial subtractor
interface serial_ripple_subtractor_if #(parameter int WIDTH = 4);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] Diff;
    logic             Bout;
    logic             Ovf;
    modport master (output start, A, B, Bin, input busy, done, Diff, Bout, Ovf);
    modport slave  (input start, A, B, Bin, output busy, done, Diff, Bout, Ovf);
endinterface

// File: rtl/serial_ripple_subtractor.sv
// serial_ripple_subtractor: bit-serial A - B - Bin, LSB first, one bit per clock behind start/done
module serial_ripple_subtractor #(parameter int WIDTH = 4) (
    input logic clk,
    input logic rst,
    serial_ripple_subtractor_if.slave s
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t           state;
    logic [WIDTH-1:0] a_sh, b_sh, res;
    logic [CW-1:0]    cnt;
    logic             br, a, b, d, br_n;
    assign a    = a_sh[0];
    assign b    = b_sh[0];
    assign d    = a ^ b ^ br;
    assign br_n = (~a & b) | (~(a ^ b) & br);
    // on the last bit the shift registers expose the operand MSBs, so overflow is taken from them
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            a_sh   <= '0;
            b_sh   <= '0;
            res    <= '0;
            br     <= 1'b0;
            cnt    <= '0;
            s.busy <= 1'b0;
            s.done <= 1'b0;
            s.Diff <= '0;
            s.Bout <= 1'b0;
            s.Ovf  <= 1'b0;
        end else begin
            s.done <= 1'b0;
            if (state == RUN) begin
                a_sh <= a_sh >> 1;
                b_sh <= b_sh >> 1;
                res  <= {d, res[WIDTH-1:1]};
                br   <= br_n;
                cnt  <= cnt + CW'(1);
                if (cnt == CW'(WIDTH - 1)) begin
                    state  <= DONE;
                    s.busy <= 1'b0;
                    s.done <= 1'b1;
                    s.Diff <= {d, res[WIDTH-1:1]};
                    s.Bout <= br_n;
                    s.Ovf  <= (a ^ b) & (d ^ a);
                end
            end else if (s.start) begin
                state  <= RUN;
                a_sh   <= s.A;
                b_sh   <= s.B;
                br     <= s.Bin;
                cnt    <= '0;
                s.busy <= 1'b1;
            end else begin
                state <= IDLE;
            end
        end
    end
endmodule
